ddr_cmd_lane_tx_ctrl: RTL and testbench
=======================================

// Module: ddr_cmd_lane_tx_ctrl
// PURPOSE
//  Parametrised fabric-side driver for NUM_CH DDR command/address output pins.
//  - Registers per-pin TX and OE words and expands them into the 2*RATIO-bit word the IOD serializer expects.
//  - Contains a per-pin delay-line controller with a req/ack handshake, tap tracking and range checking.
//  - Sits between the DDR PHY command sequencer / training logic and the per-pin IOD+TRIBUFF instances.
// PARAMETERS
//  NUM_CH     1    number of command/address pins driven
//  RATIO      4    fabric-to-pad serialization ratio (data bits per pin per FAB_CLK)
//  CMD_SDR    1    1: SDR command pins, zero-stuff odd output bits; 0: 2*RATIO input bits passed through
//  TAP_W      8    width of tap counter
//  MAX_TAP    255  highest legal tap value
//  INIT_TAP   1    tap value after reset or LOAD
//  MOVE_GAP   2    settle cycles after each MOVE/LOAD pulse (>=1)
// PORTS  (IW = CMD_SDR ? RATIO : 2*RATIO)
//  FAB_CLK                  in   1              fabric clock; all logic is on this edge
//  ARST_N                   in   1              asynchronous active-low reset
//  TX_SYNC_RST              in   1              synchronous clear of data/OE pipe only
//  TX_DATA_IN               in   NUM_CH*IW      per-pin parallel data, bit 0 first on pad
//  OE_IN                    in   NUM_CH*RATIO   per-pin output enable, 1 = drive
//  TX_DATA_OUT              out  NUM_CH*2*RATIO to IOD TX_DATA
//  OE_OUT                   out  NUM_CH*RATIO   to IOD OE_DATA
//  DLY_REQ                  in   NUM_CH         request a one-tap move
//  DLY_DIR                  in   NUM_CH         1 = increment, 0 = decrement; sampled with DLY_REQ
//  DLY_LOAD_REQ             in   NUM_CH         request reload to INIT_TAP
//  DLY_ACK                  out  NUM_CH         1-cycle completion pulse
//  DLY_BUSY                 out  NUM_CH         FSM not IDLE
//  DLY_ERR                  out  NUM_CH         sticky range error
//  TAP_CNT                  out  NUM_CH*TAP_W   current tap value
//  DELAY_LINE_MOVE          out  NUM_CH         to IOD
//  DELAY_LINE_DIRECTION     out  NUM_CH         to IOD
//  DELAY_LINE_LOAD          out  NUM_CH         to IOD
//  DELAY_LINE_OUT_OF_RANGE  in   NUM_CH         from IOD
// BEHAVIOUR
//  Reset (ARST_N=0, async):
//   - TX_DATA_OUT=0, OE_OUT=0 (pad tristated); MOVE/LOAD/DIRECTION=0.
//   - DLY_ACK=0, DLY_BUSY=0, DLY_ERR=0, TAP_CNT=INIT_TAP, FSM=IDLE.
//   - An in-flight move is aborted with no ACK.
//  Data path (1-cycle latency, registered):
//   - CMD_SDR=1: out[2i]=in[i], out[2i+1]=0.
//   - CMD_SDR=0: out=in.
//   - OE_OUT=OE_IN.
//   - TX_SYNC_RST=1 forces both registers to 0 next edge; it does not affect the delay FSM.
//  Delay FSM per channel: IDLE -> MOVE|LOAD -> SETTLE -> ACK -> IDLE
//   - Requests are accepted only in IDLE; requests while BUSY are ignored, never queued.
//   - DLY_LOAD_REQ and DLY_REQ in the same cycle: load wins and the move is dropped.
//   - LOAD: DELAY_LINE_LOAD=1 for 1 cycle; TAP_CNT=INIT_TAP; DLY_ERR cleared.
//   - MOVE, legal: DELAY_LINE_MOVE=1 for 1 cycle; DIRECTION=DLY_DIR held from MOVE through SETTLE; TAP_CNT +/-1 on MOVE cycle.
//   - MOVE, illegal (inc at MAX_TAP, dec at 0): no MOVE pulse; DLY_ERR=1; TAP unchanged; skip SETTLE and go to ACK.
//   - SETTLE: lasts MOVE_GAP cycles. If OUT_OF_RANGE=1 in any SETTLE cycle, DLY_ERR=1 and the TAP_CNT step is reverted at the last SETTLE cycle.
//   - ACK: DLY_ACK=1 for exactly 1 cycle.
//   - Latency req -> ACK is MOVE_GAP+2 cycles (legal) and 2 cycles (illegal).
//   - DLY_BUSY=1 from the cycle after acceptance through the ACK cycle.
//   - Channels are fully independent.
// TESTING
//  1 Reset: ARST_N low mid-SETTLE -> all outputs at reset values immediately, TAP_CNT=1, no ACK after release.
//  2 Data: CMD_SDR=1, TX_DATA_IN=4'b1011, OE_IN=4'hF -> next cycle TX_DATA_OUT=8'b01000101, OE_OUT=4'hF; TX_SYNC_RST -> both 0.
//  3 Tap walk: 3 inc requests from INIT_TAP=1 -> 3 MOVE pulses with DIR=1; TAP_CNT=4; each ACK arrives 4 cycles after its REQ (MOVE_GAP=2).
//  4 Bounds: dec at TAP 0 -> no MOVE, ACK after 2 cycles, DLY_ERR=1; inc at 255 -> same behaviour; then LOAD -> LOAD pulse, TAP=1, ERR=0.
//  5 Range: OUT_OF_RANGE=1 during SETTLE of an inc from 10 -> ERR=1, TAP_CNT returns to 10, ACK issued.
//  6 Contention: REQ+LOAD_REQ in the same cycle -> only LOAD executes, one ACK; REQ while BUSY -> ignored, no second ACK.

Source files
------------

// File: rtl/ddr_cmd_lane_tx_ctrl.sv
// Fabric-side driver for DDR command/address pins: registered TX/OE expansion into the
// IOD serializer word, plus a per-pin delay-line controller with tap tracking.
module ddr_cmd_lane_tx_ctrl #(
  parameter int NUM_CH   = 1,
  parameter int RATIO    = 4,
  parameter int CMD_SDR  = 1,
  parameter int TAP_W    = 8,
  parameter int MAX_TAP  = 255,
  parameter int INIT_TAP = 1,
  parameter int MOVE_GAP = 2,
  localparam int IW      = (CMD_SDR != 0) ? RATIO : 2 * RATIO
) (
  input  logic                        FAB_CLK,
  input  logic                        ARST_N,
  input  logic                        TX_SYNC_RST,
  input  logic [NUM_CH*IW-1:0]        TX_DATA_IN,
  input  logic [NUM_CH*RATIO-1:0]     OE_IN,
  output logic [NUM_CH*2*RATIO-1:0]   TX_DATA_OUT,
  output logic [NUM_CH*RATIO-1:0]     OE_OUT,
  input  logic [NUM_CH-1:0]           DLY_REQ,
  input  logic [NUM_CH-1:0]           DLY_DIR,
  input  logic [NUM_CH-1:0]           DLY_LOAD_REQ,
  output logic [NUM_CH-1:0]           DLY_ACK,
  output logic [NUM_CH-1:0]           DLY_BUSY,
  output logic [NUM_CH-1:0]           DLY_ERR,
  output logic [NUM_CH*TAP_W-1:0]     TAP_CNT,
  output logic [NUM_CH-1:0]           DELAY_LINE_MOVE,
  output logic [NUM_CH-1:0]           DELAY_LINE_DIRECTION,
  output logic [NUM_CH-1:0]           DELAY_LINE_LOAD,
  input  logic [NUM_CH-1:0]           DELAY_LINE_OUT_OF_RANGE
);

  localparam int CW = (MOVE_GAP > 1) ? $clog2(MOVE_GAP) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MOVE   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_ACK    = 3'd4
  } dly_state_e;

  logic [NUM_CH*2*RATIO-1:0] tx_exp_s;
  logic [NUM_CH*2*RATIO-1:0] tx_data_r;
  logic [NUM_CH*RATIO-1:0]   oe_r;

  // SDR pins carry each command bit on the even slot only; odd slots are zero-stuffed.
  always_comb begin
    tx_exp_s = '0;
    if (CMD_SDR != 0) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int i = 0; i < RATIO; i++) begin
          tx_exp_s[c*2*RATIO + 2*i] = TX_DATA_IN[c*IW + i];
        end
      end
    end else begin
      for (int k = 0; k < NUM_CH*IW; k++) begin
        tx_exp_s[k] = TX_DATA_IN[k];
      end
    end
  end

  // Data/OE pipe register; the sync clear tristates the pad without touching the delay logic.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      tx_data_r <= '0;
      oe_r      <= '0;
    end else if (TX_SYNC_RST) begin
      tx_data_r <= '0;
      oe_r      <= '0;
    end else begin
      tx_data_r <= tx_exp_s;
      oe_r      <= OE_IN;
    end
  end

  assign TX_DATA_OUT = tx_data_r;
  assign OE_OUT      = oe_r;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_dly
    dly_state_e       state_r;
    dly_state_e       state_s;
    logic [CW-1:0]    settle_cnt_r;
    logic [TAP_W-1:0] tap_r;
    logic             dir_r;
    logic             illegal_r;
    logic             was_move_r;
    logic             oor_seen_r;
    logic             err_r;
    logic             ack_r;
    logic             busy_r;
    logic             move_r;
    logic             load_r;
    logic             dir_out_r;
    logic             illegal_s;
    logic             last_settle_s;
    logic             accept_load_s;
    logic             accept_move_s;

    assign illegal_s     = DLY_DIR[g] ? (tap_r == TAP_W'(MAX_TAP)) : (tap_r == '0);
    assign last_settle_s = (settle_cnt_r == CW'(MOVE_GAP - 1));
    assign accept_load_s = (state_r == ST_IDLE) && DLY_LOAD_REQ[g];
    assign accept_move_s = (state_r == ST_IDLE) && !DLY_LOAD_REQ[g] && DLY_REQ[g];

    // Next-state logic; a load request outranks a simultaneous move request.
    always_comb begin
      state_s = state_r;
      case (state_r)
        ST_IDLE: begin
          if (DLY_LOAD_REQ[g]) state_s = ST_LOAD;
          else if (DLY_REQ[g]) state_s = ST_MOVE;
          else state_s = ST_IDLE;
        end
        ST_MOVE: begin
          if (illegal_r) state_s = ST_ACK;
          else state_s = ST_SETTLE;
        end
        ST_LOAD:   state_s = ST_SETTLE;
        ST_SETTLE: begin
          if (last_settle_s) state_s = ST_ACK;
          else state_s = ST_SETTLE;
        end
        ST_ACK:    state_s = ST_IDLE;
        default:   state_s = ST_IDLE;
      endcase
    end

    // State, tap tracking and registered IOD/handshake outputs for one pin.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
      if (!ARST_N) begin
        state_r      <= ST_IDLE;
        settle_cnt_r <= '0;
        tap_r        <= TAP_W'(INIT_TAP);
        dir_r        <= 1'b0;
        illegal_r    <= 1'b0;
        was_move_r   <= 1'b0;
        oor_seen_r   <= 1'b0;
        err_r        <= 1'b0;
        ack_r        <= 1'b0;
        busy_r       <= 1'b0;
        move_r       <= 1'b0;
        load_r       <= 1'b0;
        dir_out_r    <= 1'b0;
      end else begin
        state_r      <= state_s;
        ack_r        <= (state_s == ST_ACK);
        busy_r       <= (state_s != ST_IDLE);
        move_r       <= accept_move_s && !illegal_s;
        load_r       <= accept_load_s;
        settle_cnt_r <= (state_r == ST_SETTLE) ? settle_cnt_r + CW'(1) : '0;
        if (accept_load_s) begin
          tap_r      <= TAP_W'(INIT_TAP);
          err_r      <= 1'b0;
          was_move_r <= 1'b0;
          oor_seen_r <= 1'b0;
          dir_out_r  <= 1'b0;
        end else if (accept_move_s) begin
          dir_r      <= DLY_DIR[g];
          illegal_r  <= illegal_s;
          was_move_r <= 1'b1;
          oor_seen_r <= 1'b0;
          if (illegal_s) begin
            err_r     <= 1'b1;
            dir_out_r <= 1'b0;
          end else begin
            tap_r     <= DLY_DIR[g] ? tap_r + TAP_W'(1) : tap_r - TAP_W'(1);
            dir_out_r <= DLY_DIR[g];
          end
        end else if (state_r == ST_SETTLE) begin
          if (DELAY_LINE_OUT_OF_RANGE[g]) begin
            err_r      <= 1'b1;
            oor_seen_r <= 1'b1;
          end
          // The IOD refused the step: undo the optimistic tap update.
          if (last_settle_s) begin
            dir_out_r <= 1'b0;
            if (was_move_r && (oor_seen_r || DELAY_LINE_OUT_OF_RANGE[g])) begin
              tap_r <= dir_r ? tap_r - TAP_W'(1) : tap_r + TAP_W'(1);
            end
          end
        end
      end
    end

    assign DLY_ACK[g]                  = ack_r;
    assign DLY_BUSY[g]                 = busy_r;
    assign DLY_ERR[g]                  = err_r;
    assign TAP_CNT[g*TAP_W +: TAP_W]   = tap_r;
    assign DELAY_LINE_MOVE[g]          = move_r;
    assign DELAY_LINE_LOAD[g]          = load_r;
    assign DELAY_LINE_DIRECTION[g]     = dir_out_r;
  end

endmodule

// File: tb/tb_ddr_cmd_lane_tx_ctrl.sv
// Bench for ddr_cmd_lane_tx_ctrl (default parameters, one channel): expected ACKs are
// queued with cycle/tap/err when a request is driven and checked when the ACK appears.
module tb_ddr_cmd_lane_tx_ctrl;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       tx_sync_rst;
  logic [3:0] tx_data_in;
  logic [3:0] oe_in;
  logic [7:0] tx_data_out;
  logic [3:0] oe_out;
  logic       dly_req, dly_dir, dly_load_req;
  logic       dly_ack, dly_busy, dly_err;
  logic [7:0] tap_cnt;
  logic       dl_move, dl_dir, dl_load, dl_oor;

  ddr_cmd_lane_tx_ctrl dut (
    .FAB_CLK                 (clk),
    .ARST_N                  (arst_n),
    .TX_SYNC_RST             (tx_sync_rst),
    .TX_DATA_IN              (tx_data_in),
    .OE_IN                   (oe_in),
    .TX_DATA_OUT             (tx_data_out),
    .OE_OUT                  (oe_out),
    .DLY_REQ                 (dly_req),
    .DLY_DIR                 (dly_dir),
    .DLY_LOAD_REQ            (dly_load_req),
    .DLY_ACK                 (dly_ack),
    .DLY_BUSY                (dly_busy),
    .DLY_ERR                 (dly_err),
    .TAP_CNT                 (tap_cnt),
    .DELAY_LINE_MOVE         (dl_move),
    .DELAY_LINE_DIRECTION    (dl_dir),
    .DELAY_LINE_LOAD         (dl_load),
    .DELAY_LINE_OUT_OF_RANGE (dl_oor)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] tap;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  int         cycle = 0;
  int         move_cnt = 0;
  int         move_inc_cnt = 0;
  int         load_cnt = 0;
  int         ack_cnt = 0;
  logic [7:0] model_tap;
  logic       model_err;

  // One clock step: sample at the falling edge and service the ACK scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cycle++;
    if (dl_move === 1'b1) begin
      move_cnt++;
      if (dl_dir === 1'b1) move_inc_cnt++;
    end
    if (dl_load === 1'b1) load_cnt++;
    if (dly_ack === 1'b1) begin
      ack_cnt++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL ack_unexpected: cycle=%0d tap=%0d err=%0b, required no ACK", cycle, tap_cnt, dly_err);
      end else begin
        e = sb.pop_front();
        if (cycle !== e.cyc || tap_cnt !== e.tap || dly_err !== e.err) begin
          bad++;
          $display("FAIL ack_check: got cycle=%0d tap=%0d err=%0b, required cycle=%0d tap=%0d err=%0b",
                   cycle, tap_cnt, dly_err, e.cyc, e.tap, e.err);
        end
      end
    end
    if (sb.size() > 0 && cycle > sb[0].cyc) begin
      total++;
      bad++;
      $display("FAIL ack_missing: no ACK at cycle %0d (now %0d)", sb[0].cyc, cycle);
      void'(sb.pop_front());
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 16 && sb.size() > 0; i++) tick();
    total++;
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL ack_timeout: %0d ACKs outstanding, required 0", sb.size());
      sb.delete();
    end
    tick();
  endtask

  task automatic issue_move(input logic dir, input logic oor);
    exp_t e;
    logic legal;
    legal = dir ? (model_tap != 8'd255) : (model_tap != 8'd0);
    if (!legal) model_err = 1'b1;
    else if (oor) model_err = 1'b1;
    else model_tap = dir ? model_tap + 8'd1 : model_tap - 8'd1;
    e.cyc = cycle + (legal ? 4 : 2);
    e.tap = model_tap;
    e.err = model_err;
    sb.push_back(e);
    dly_req = 1'b1;
    dly_dir = dir;
    tick();
    dly_req = 1'b0;
    if (oor) begin
      dl_oor = 1'b1;
      tick();
      tick();
      dl_oor = 1'b0;
    end
    wait_done();
  endtask

  task automatic issue_load();
    exp_t e;
    model_tap = 8'd1;
    model_err = 1'b0;
    e.cyc = cycle + 4;
    e.tap = model_tap;
    e.err = model_err;
    sb.push_back(e);
    dly_load_req = 1'b1;
    tick();
    dly_load_req = 1'b0;
    wait_done();
  endtask

  task automatic test_reset();
    int acks;
    total++;
    if (tx_data_out !== 8'h00 || oe_out !== 4'h0 || dly_ack !== 1'b0 || dly_busy !== 1'b0 ||
        dly_err !== 1'b0 || tap_cnt !== 8'd1 || dl_move !== 1'b0 || dl_load !== 1'b0 || dl_dir !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: data=%h oe=%h ack=%b busy=%b err=%b tap=%0d mv=%b ld=%b dir=%b, required all 0 and tap=1",
               tx_data_out, oe_out, dly_ack, dly_busy, dly_err, tap_cnt, dl_move, dl_load, dl_dir);
    end
    arst_n = 1'b1;
    tick();
    dly_req = 1'b1;
    dly_dir = 1'b1;
    tick();
    dly_req = 1'b0;
    tick();
    acks = ack_cnt;
    arst_n = 1'b0;
    #1;
    total++;
    if (tap_cnt !== 8'd1 || dly_busy !== 1'b0 || dl_dir !== 1'b0 || dly_ack !== 1'b0 || dly_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_settle: tap=%0d busy=%b dir=%b ack=%b err=%b, required tap=1 rest 0",
               tap_cnt, dly_busy, dl_dir, dly_ack, dly_err);
    end
    tick();
    arst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    total++;
    if (ack_cnt !== acks) begin
      bad++;
      $display("FAIL reset_abort_ack: acks=%0d, required %0d", ack_cnt, acks);
    end
    model_tap = 8'd1;
    model_err = 1'b0;
  endtask

  task automatic test_data();
    tx_data_in = 4'b1011;
    oe_in      = 4'hF;
    tick();
    total++;
    if (tx_data_out !== 8'b01000101 || oe_out !== 4'hF) begin
      bad++;
      $display("FAIL data_sdr_a: data=%b oe=%h, required 01000101 f", tx_data_out, oe_out);
    end
    tx_data_in = 4'b0110;
    oe_in      = 4'h5;
    tick();
    total++;
    if (tx_data_out !== 8'b00010100 || oe_out !== 4'h5) begin
      bad++;
      $display("FAIL data_sdr_b: data=%b oe=%h, required 00010100 5", tx_data_out, oe_out);
    end
    tx_sync_rst = 1'b1;
    tick();
    total++;
    if (tx_data_out !== 8'h00 || oe_out !== 4'h0) begin
      bad++;
      $display("FAIL data_sync_rst: data=%b oe=%h, required 0 0", tx_data_out, oe_out);
    end
    tx_sync_rst = 1'b0;
    tick();
    total++;
    if (tx_data_out !== 8'b00010100 || oe_out !== 4'h5) begin
      bad++;
      $display("FAIL data_resume: data=%b oe=%h, required 00010100 5", tx_data_out, oe_out);
    end
  endtask

  task automatic test_tap_walk();
    int m0, i0;
    m0 = move_cnt;
    i0 = move_inc_cnt;
    for (int k = 0; k < 3; k++) issue_move(1'b1, 1'b0);
    total++;
    if (move_cnt - m0 !== 3 || move_inc_cnt - i0 !== 3 || tap_cnt !== 8'd4 || dly_busy !== 1'b0) begin
      bad++;
      $display("FAIL tap_walk: moves=%0d inc=%0d tap=%0d busy=%b, required 3 3 4 0",
               move_cnt - m0, move_inc_cnt - i0, tap_cnt, dly_busy);
    end
  endtask

  task automatic test_bounds();
    int m0, l0;
    issue_load();
    m0 = move_cnt;
    issue_move(1'b0, 1'b0);
    issue_move(1'b0, 1'b0);
    total++;
    if (move_cnt - m0 !== 1 || tap_cnt !== 8'd0 || dly_err !== 1'b1) begin
      bad++;
      $display("FAIL bound_low: moves=%0d tap=%0d err=%b, required 1 0 1", move_cnt - m0, tap_cnt, dly_err);
    end
    issue_load();
    for (int k = 0; k < 254; k++) issue_move(1'b1, 1'b0);
    m0 = move_cnt;
    issue_move(1'b1, 1'b0);
    total++;
    if (move_cnt - m0 !== 0 || tap_cnt !== 8'd255 || dly_err !== 1'b1) begin
      bad++;
      $display("FAIL bound_high: moves=%0d tap=%0d err=%b, required 0 255 1", move_cnt - m0, tap_cnt, dly_err);
    end
    l0 = load_cnt;
    issue_load();
    total++;
    if (load_cnt - l0 !== 1 || tap_cnt !== 8'd1 || dly_err !== 1'b0) begin
      bad++;
      $display("FAIL bound_load: loads=%0d tap=%0d err=%b, required 1 1 0", load_cnt - l0, tap_cnt, dly_err);
    end
  endtask

  task automatic test_range();
    for (int k = 0; k < 9; k++) issue_move(1'b1, 1'b0);
    total++;
    if (tap_cnt !== 8'd10) begin
      bad++;
      $display("FAIL range_setup: tap=%0d, required 10", tap_cnt);
    end
    issue_move(1'b1, 1'b1);
    total++;
    if (tap_cnt !== 8'd10 || dly_err !== 1'b1) begin
      bad++;
      $display("FAIL range_revert: tap=%0d err=%b, required 10 1", tap_cnt, dly_err);
    end
    issue_load();
  endtask

  task automatic test_contention();
    int m0, l0, a0;
    exp_t e;
    issue_move(1'b1, 1'b0);
    m0 = move_cnt;
    l0 = load_cnt;
    a0 = ack_cnt;
    model_tap = 8'd1;
    model_err = 1'b0;
    e.cyc = cycle + 4;
    e.tap = model_tap;
    e.err = model_err;
    sb.push_back(e);
    dly_req      = 1'b1;
    dly_dir      = 1'b1;
    dly_load_req = 1'b1;
    tick();
    dly_load_req = 1'b0;
    tick();
    tick();
    dly_req = 1'b0;
    wait_done();
    for (int i = 0; i < 6; i++) tick();
    total++;
    if (move_cnt - m0 !== 0 || load_cnt - l0 !== 1 || ack_cnt - a0 !== 1 || tap_cnt !== 8'd1) begin
      bad++;
      $display("FAIL contention: moves=%0d loads=%0d acks=%0d tap=%0d, required 0 1 1 1",
               move_cnt - m0, load_cnt - l0, ack_cnt - a0, tap_cnt);
    end
  endtask

  initial begin
    arst_n       = 1'b0;
    tx_sync_rst  = 1'b0;
    tx_data_in   = 4'h0;
    oe_in        = 4'h0;
    dly_req      = 1'b0;
    dly_dir      = 1'b0;
    dly_load_req = 1'b0;
    dl_oor       = 1'b0;
    model_tap    = 8'd1;
    model_err    = 1'b0;
    tick();
    test_reset();
    test_data();
    test_tap_walk();
    test_bounds();
    test_range();
    test_contention();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
